// File: rtl/csr_regfile.sv
// rtl/csr_regfile.sv - LoongArch CSR file with exception entry, ertn return, timer and interrupt aggregation
module csr_regfile #(
    parameter logic [31:0] TID_INIT = 32'h0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [13:0] csr_num,
    output logic [31:0] csr_rvalue,
    input  logic        csr_we,
    input  logic [31:0] csr_wmask,
    input  logic [31:0] csr_wvalue,
    input  logic        wb_ex,
    input  logic [5:0]  wb_ecode,
    input  logic [8:0]  wb_esubcode,
    input  logic [31:0] wb_pc,
    input  logic        ertn_flush,
    input  logic [7:0]  hw_int_in,
    input  logic        ipi_int_in,
    output logic        has_int,
    output logic [31:0] ex_entry,
    output logic [31:0] ertn_entry
);

    localparam logic [13:0] ADDR_CRMD   = 14'h00;
    localparam logic [13:0] ADDR_PRMD   = 14'h01;
    localparam logic [13:0] ADDR_ECFG   = 14'h04;
    localparam logic [13:0] ADDR_ESTAT  = 14'h05;
    localparam logic [13:0] ADDR_ERA    = 14'h06;
    localparam logic [13:0] ADDR_EENTRY = 14'h0C;
    localparam logic [13:0] ADDR_SAVE0  = 14'h30;
    localparam logic [13:0] ADDR_SAVE1  = 14'h31;
    localparam logic [13:0] ADDR_SAVE2  = 14'h32;
    localparam logic [13:0] ADDR_SAVE3  = 14'h33;
    localparam logic [13:0] ADDR_TID    = 14'h40;
    localparam logic [13:0] ADDR_TCFG   = 14'h41;
    localparam logic [13:0] ADDR_TVAL   = 14'h42;
    localparam logic [13:0] ADDR_TICLR  = 14'h44;

    logic [8:0]  crmd;
    logic [2:0]  prmd;
    logic [12:0] ecfg;
    logic [12:0] estat_is;
    logic [5:0]  estat_ecode;
    logic [8:0]  estat_esubcode;
    logic [31:0] era;
    logic [25:0] eentry;
    logic [31:0] save0, save1, save2, save3;
    logic [31:0] tid;
    logic [31:0] tcfg;
    logic [31:0] counter;

    logic        wr_en;
    logic [31:0] wdata;
    logic        timer_expire;
    logic        ticlr_clear;

    always_comb begin
        csr_rvalue = 32'h0;
        case (csr_num)
            ADDR_CRMD:   csr_rvalue = {23'h0, crmd};
            ADDR_PRMD:   csr_rvalue = {29'h0, prmd};
            ADDR_ECFG:   csr_rvalue = {19'h0, ecfg};
            ADDR_ESTAT:  csr_rvalue = {1'b0, estat_esubcode, estat_ecode, 3'b0, estat_is};
            ADDR_ERA:    csr_rvalue = era;
            ADDR_EENTRY: csr_rvalue = {eentry, 6'h0};
            ADDR_SAVE0:  csr_rvalue = save0;
            ADDR_SAVE1:  csr_rvalue = save1;
            ADDR_SAVE2:  csr_rvalue = save2;
            ADDR_SAVE3:  csr_rvalue = save3;
            ADDR_TID:    csr_rvalue = tid;
            ADDR_TCFG:   csr_rvalue = tcfg;
            ADDR_TVAL:   csr_rvalue = counter;
            default:     csr_rvalue = 32'h0;
        endcase
    end

    // The read mux already holds the addressed register's old value, so one merge serves every CSR.
    assign wr_en = csr_we & ~wb_ex & ~ertn_flush;
    assign wdata = (csr_rvalue & ~csr_wmask) | (csr_wvalue & csr_wmask);

    assign timer_expire = tcfg[0] & (counter == 32'h0);
    assign ticlr_clear  = wr_en & (csr_num == ADDR_TICLR) & wdata[0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            crmd <= 9'h008;
            prmd <= 3'h0;
            era  <= 32'h0;
            estat_ecode    <= 6'h0;
            estat_esubcode <= 9'h0;
        end else if (wb_ex) begin
            prmd        <= crmd[2:0];
            crmd[2:0]   <= 3'h0;
            era         <= wb_pc;
            estat_ecode    <= wb_ecode;
            estat_esubcode <= wb_esubcode;
        end else if (ertn_flush) begin
            crmd[2:0] <= prmd;
        end else if (wr_en) begin
            if (csr_num == ADDR_CRMD) crmd <= wdata[8:0];
            if (csr_num == ADDR_PRMD) prmd <= wdata[2:0];
            if (csr_num == ADDR_ERA)  era  <= wdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ecfg   <= 13'h0;
            eentry <= 26'h0;
            save0  <= 32'h0;
            save1  <= 32'h0;
            save2  <= 32'h0;
            save3  <= 32'h0;
            tid    <= TID_INIT;
            tcfg   <= 32'h0;
        end else if (wr_en) begin
            case (csr_num)
                ADDR_ECFG:   ecfg   <= wdata[12:0] & 13'h1BFF;
                ADDR_EENTRY: eentry <= wdata[31:6];
                ADDR_SAVE0:  save0  <= wdata;
                ADDR_SAVE1:  save1  <= wdata;
                ADDR_SAVE2:  save2  <= wdata;
                ADDR_SAVE3:  save3  <= wdata;
                ADDR_TID:    tid    <= wdata;
                ADDR_TCFG:   tcfg   <= wdata;
                default: ;
            endcase
        end
    end

    // IS[9:2] and IS[12] are level samples; IS[11] is sticky until TICLR, with expiry winning.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            estat_is <= 13'h0;
        end else begin
            if (wr_en && csr_num == ADDR_ESTAT) estat_is[1:0] <= wdata[1:0];
            estat_is[9:2] <= hw_int_in;
            estat_is[10]  <= 1'b0;
            if (timer_expire)     estat_is[11] <= 1'b1;
            else if (ticlr_clear) estat_is[11] <= 1'b0;
            estat_is[12] <= ipi_int_in;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            counter <= 32'hFFFF_FFFF;
        end else if (wr_en && csr_num == ADDR_TCFG) begin
            counter <= {wdata[31:2], 2'b00};
        end else if (timer_expire) begin
            counter <= tcfg[1] ? {tcfg[31:2], 2'b00} : 32'hFFFF_FFFF;
        end else if (tcfg[0] && counter != 32'hFFFF_FFFF) begin
            counter <= counter - 32'h1;
        end
    end

    assign has_int    = crmd[2] & (|(estat_is & ecfg));
    assign ex_entry   = {eentry, 6'h0};
    assign ertn_entry = era;

endmodule

// File: tb/tb_csr_regfile.sv
// tb/tb_csr_regfile.sv - scoreboard bench for csr_regfile with directed vectors
module tb_csr_regfile;

    localparam logic [31:0] TID_VAL = 32'h0000_00A5;

    logic        clk = 1'b0;
    logic        resetn;
    logic [13:0] csr_num;
    logic [31:0] csr_rvalue;
    logic        csr_we;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        wb_ex;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_pc;
    logic        ertn_flush;
    logic [7:0]  hw_int_in;
    logic        ipi_int_in;
    logic        has_int;
    logic [31:0] ex_entry;
    logic [31:0] ertn_entry;

    csr_regfile #(.TID_INIT(TID_VAL)) dut (
        .clk(clk), .resetn(resetn), .csr_num(csr_num), .csr_rvalue(csr_rvalue),
        .csr_we(csr_we), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
        .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_pc(wb_pc),
        .ertn_flush(ertn_flush), .hw_int_in(hw_int_in), .ipi_int_in(ipi_int_in),
        .has_int(has_int), .ex_entry(ex_entry), .ertn_entry(ertn_entry)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          sel;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    logic rd_req = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(negedge clk) begin
        if (rd_req) begin
            exp_t        e;
            logic [31:0] act;
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_sample: no expected entry queued");
            end else begin
                e = sb.pop_front();
                case (e.sel)
                    1:       act = {31'h0, has_int};
                    2:       act = ex_entry;
                    3:       act = ertn_entry;
                    default: act = csr_rvalue;
                endcase
                if (act !== e.exp) begin
                    n_bad++;
                    $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input int sel, input logic [31:0] exp, input string name);
        exp_t e;
        e.sel = sel; e.exp = exp; e.name = name;
        sb.push_back(e);
        rd_req = 1'b1;
        @(negedge clk);
        #1 rd_req = 1'b0;
    endtask

    task automatic chk(input logic [13:0] num, input logic [31:0] exp, input string name);
        csr_num = num;
        sample(0, exp, name);
    endtask

    task automatic wr(input logic [13:0] num, input logic [31:0] mask, input logic [31:0] val);
        csr_num = num; csr_wmask = mask; csr_wvalue = val; csr_we = 1'b1;
        tick();
        csr_we = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; csr_num = '0; csr_we = 1'b0; csr_wmask = '0; csr_wvalue = '0;
        wb_ex = 1'b0; wb_ecode = '0; wb_esubcode = '0; wb_pc = '0; ertn_flush = 1'b0;
        hw_int_in = '0; ipi_int_in = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;

        chk(14'h00, 32'h8, "rst_crmd");
        chk(14'h01, 32'h0, "rst_prmd");
        chk(14'h04, 32'h0, "rst_ecfg");
        chk(14'h05, 32'h0, "rst_estat");
        chk(14'h06, 32'h0, "rst_era");
        chk(14'h0C, 32'h0, "rst_eentry");
        for (int i = 0; i < 4; i++) chk(14'h30 + 14'(i), 32'h0, "rst_save");
        chk(14'h40, TID_VAL, "rst_tid");
        chk(14'h41, 32'h0, "rst_tcfg");
        chk(14'h42, 32'hFFFF_FFFF, "rst_tval");
        chk(14'h44, 32'h0, "rst_ticlr");
        sample(1, 32'h0, "rst_has_int");

        wr(14'h31, 32'hFFFF_FFFF, 32'h1234_5678);
        wr(14'h31, 32'h0000_FFFF, 32'hDEAD_BEEF);
        chk(14'h31, 32'h1234_BEEF, "save1_masked");
        wr(14'h04, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk(14'h04, 32'h0000_1BFF, "ecfg_ones");
        wr(14'h0C, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk(14'h0C, 32'hFFFF_FFC0, "eentry_low_zero");
        sample(2, 32'hFFFF_FFC0, "ex_entry");
        wr(14'h02, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk(14'h02, 32'h0, "unmapped_read");
        wr(14'h42, 32'hFFFF_FFFF, 32'h0000_0010);
        chk(14'h42, 32'hFFFF_FFFF, "tval_read_only");
        wr(14'h05, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk(14'h05, 32'h3, "estat_is_rw");
        wr(14'h05, 32'hFFFF_FFFF, 32'h0);

        wr(14'h00, 32'hFFFF_FFFF, 32'h7);
        chk(14'h00, 32'h7, "crmd_write");
        wb_ex = 1'b1; wb_ecode = 6'h0B; wb_esubcode = 9'h001; wb_pc = 32'h1C00_0100;
        tick();
        wb_ex = 1'b0;
        chk(14'h00, 32'h0, "ex_crmd");
        chk(14'h01, 32'h7, "ex_prmd");
        chk(14'h06, 32'h1C00_0100, "ex_era");
        chk(14'h05, 32'h004B_0000, "ex_estat");
        sample(3, 32'h1C00_0100, "ertn_entry");
        ertn_flush = 1'b1;
        tick();
        ertn_flush = 1'b0;
        chk(14'h00, 32'h7, "ertn_crmd");
        sample(1, 32'h0, "no_int_pending");

        hw_int_in = 8'h01;
        tick();
        chk(14'h05, 32'h004B_0004, "hw_int_sample");
        sample(1, 32'h1, "hw_has_int");
        hw_int_in = 8'h00;
        tick();
        sample(1, 32'h0, "hw_int_drop");

        wb_ex = 1'b1; wb_ecode = 6'h08; wb_esubcode = 9'h0; wb_pc = 32'h1C00_0200;
        csr_num = 14'h00; csr_wmask = 32'hFFFF_FFFF; csr_wvalue = 32'h1F8; csr_we = 1'b1;
        tick();
        wb_ex = 1'b0; csr_we = 1'b0;
        chk(14'h00, 32'h0, "ex_beats_we_crmd");
        chk(14'h01, 32'h7, "ex_beats_we_prmd");
        chk(14'h06, 32'h1C00_0200, "ex_beats_we_era");
        ertn_flush = 1'b1;
        csr_num = 14'h00; csr_wmask = 32'hFFFF_FFFF; csr_wvalue = 32'h10; csr_we = 1'b1;
        tick();
        ertn_flush = 1'b0; csr_we = 1'b0;
        chk(14'h00, 32'h7, "ertn_beats_we");
        chk(14'h06, 32'h1C00_0200, "ertn_keeps_era");

        wr(14'h41, 32'hFFFF_FFFF, 32'h0000_000B);
        for (int v = 8; v >= 0; v--) begin
            chk(14'h42, 32'(v), "tval_count");
            tick();
        end
        chk(14'h42, 32'h8, "tval_reload");
        sample(1, 32'h1, "timer_has_int");
        chk(14'h05, 32'h0008_0800, "timer_is11");
        wr(14'h44, 32'hFFFF_FFFF, 32'h1);
        sample(1, 32'h0, "ticlr_has_int");
        chk(14'h05, 32'h0008_0000, "ticlr_is11");

        tick();
        #2 resetn = 1'b0;
        chk(14'h42, 32'hFFFF_FFFF, "async_rst_tval");
        chk(14'h41, 32'h0, "async_rst_tcfg");
        chk(14'h00, 32'h8, "async_rst_crmd");
        tick();
        resetn = 1'b1;
        repeat (20) tick();
        chk(14'h42, 32'hFFFF_FFFF, "post_rst_tval");
        chk(14'h05, 32'h0, "post_rst_estat");

        wr(14'h41, 32'hFFFF_FFFF, 32'h0000_0005);
        repeat (5) tick();
        repeat (3) tick();
        chk(14'h42, 32'hFFFF_FFFF, "oneshot_stop");
        chk(14'h05, 32'h0000_0800, "oneshot_is11");
        wr(14'h44, 32'h0000_0001, 32'h1);
        chk(14'h05, 32'h0, "oneshot_clear");
        wr(14'h41, 32'hFFFF_FFFF, 32'h0000_0005);
        repeat (4) tick();
        wr(14'h44, 32'hFFFF_FFFF, 32'h1);
        chk(14'h05, 32'h0000_0800, "set_beats_clear");

        tick();
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
